// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path: adjust-state flags, field
// indices and counter-width helpers.
package clock_pkg;

   localparam logic FLAG_NORM = 1'b0;
   localparam logic FLAG_ADJ  = 1'b1;

   typedef enum logic {
      ST_NORM = FLAG_NORM,
      ST_FLD  = FLAG_ADJ
   } adj_state_t;

   localparam int FLD_SEC  = 0;
   localparam int FLD_MIN  = 1;
   localparam int FLD_HOUR = 2;

   // Field-index width: $clog2(n), never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must be able to hold the value maxval.
   function automatic int cnt_width(input int maxval);
      return (maxval <= 1) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/adj_repeat.sv
// Edge detection on adjust/sig2hz plus the hold counter that paces
// auto-repeat; emits a leading strobe and per-edge repeat strobes.
module adj_repeat
   import clock_pkg::*;
#(
   parameter int HOLD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic adjust,
   input  logic sig2hz,
   input  logic restart,
   output logic first,
   output logic rep
);

   localparam int HW = cnt_width(HOLD);

   logic          primed;
   logic          adj_q;
   logic          s2_q;
   logic [HW-1:0] hcnt;
   logic          adj_rise;
   logic          s2_rise;

   // primed masks the first cycle after reset so stale history is never an edge
   assign adj_rise = primed & adjust & ~adj_q;
   assign s2_rise  = primed & sig2hz & ~s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         primed <= 1'b0;
         adj_q  <= 1'b0;
         s2_q   <= 1'b0;
         hcnt   <= '0;
      end else begin
         primed <= 1'b1;
         adj_q  <= adjust;
         s2_q   <= sig2hz;
         if (restart || !adjust)
            hcnt <= '0;
         else if (s2_rise && (hcnt < HW'(HOLD)))
            hcnt <= hcnt + 1'b1;
      end
   end

   assign first = adj_rise & ~restart;
   assign rep   = adjust & s2_rise & ~restart & (hcnt == HW'(HOLD));

endmodule

// File: rtl/adjust_ctrl.sv
// Time-setting controller: selects one of NFIELD fields, issues clear or
// increment pulses with auto-repeat, blanks the selected field, and times out.
module adjust_ctrl
   import clock_pkg::*;
#(
   parameter int                NFIELD   = 3,
   parameter logic [NFIELD-1:0] CLR_MASK = {{(NFIELD-1){1'b0}}, 1'b1},
   parameter int                TIMEOUT  = 30,
   parameter int                HOLD     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sig2hz,
   input  logic              tick1hz,
   input  logic              mode,
   input  logic              select,
   input  logic              adjust,
   output logic [NFIELD-1:0] clr,
   output logic [NFIELD-1:0] inc,
   output logic [NFIELD-1:0] on,
   output logic              adj_mode
);

   localparam int IW = idx_width(NFIELD);
   localparam int TW = cnt_width(TIMEOUT);

   adj_state_t        state_q, state_n;
   logic [IW-1:0]     idx_q, idx_n;
   logic [TW-1:0]     tcnt_q, tcnt_n;
   logic [NFIELD-1:0] clr_n, inc_n;
   logic              in_fld;
   logic              restart;
   logic              first;
   logic              rep;
   logic              tclr;
   logic              expire;

   assign in_fld   = (state_q == ST_FLD);
   assign adj_mode = in_fld;
   assign restart  = mode | select | ~in_fld;

   adj_repeat #(.HOLD(HOLD)) u_repeat (
      .clk     (clk),
      .rst     (rst),
      .adjust  (adjust),
      .sig2hz  (sig2hz),
      .restart (restart),
      .first   (first),
      .rep     (rep)
   );

   // Inactivity counter saturates at TIMEOUT; expiry is seen on the same
   // tick that would reach it, so NORM follows one cycle after that tick.
   always_comb begin
      tclr   = mode | select | adjust | ~in_fld;
      tcnt_n = tcnt_q;
      if (tclr)
         tcnt_n = '0;
      else if (tick1hz && (tcnt_q < TW'(TIMEOUT)))
         tcnt_n = tcnt_q + 1'b1;
      expire = (TIMEOUT != 0) && !tclr && (tcnt_n >= TW'(TIMEOUT));
   end

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      if (mode) begin
         state_n = in_fld ? ST_NORM : ST_FLD;
         idx_n   = '0;
      end else if (in_fld && select) begin
         idx_n = (idx_q == '0) ? IW'(NFIELD - 1) : idx_q - 1'b1;
      end else if (expire) begin
         state_n = ST_NORM;
      end
   end

   // Clear fields take only the leading pulse; increment fields also repeat.
   always_comb begin
      clr_n = '0;
      inc_n = '0;
      on    = '1;
      if (in_fld) begin
         if (first) begin
            if (CLR_MASK[idx_q])
               clr_n[idx_q] = 1'b1;
            else
               inc_n[idx_q] = 1'b1;
         end else if (rep && !CLR_MASK[idx_q]) begin
            inc_n[idx_q] = 1'b1;
         end
         if (sig2hz && !adjust)
            on[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_NORM;
         idx_q   <= '0;
         tcnt_q  <= '0;
         clr     <= '0;
         inc     <= '0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         tcnt_q  <= tcnt_n;
         clr     <= clr_n;
         inc     <= inc_n;
      end
   end

endmodule
